// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the clock display driver:
//   - digit index constants for the four multiplexed display positions
//   - 7-bit seven-segment glyphs, bit order {g,f,e,d,c,b,a}, active-high
//   - bcd2_t, a two-digit BCD field {tens, ones}
// ---------------------------------------------------------------------------
package seg7_pkg;

    // Display positions; index 0 is the rightmost digit.
    localparam logic [1:0] DIG_MIN_ONES = 2'd0;
    localparam logic [1:0] DIG_MIN_TENS = 2'd1;
    localparam logic [1:0] DIG_HR_ONES  = 2'd2;
    localparam logic [1:0] DIG_HR_TENS  = 2'd3;

    // Glyphs, active-high; polarity is applied at the output registers.
    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_DASH = 7'h40;
    localparam logic [6:0] GLYPH_OFF  = 7'h00;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/clock_display_driver_if.sv
// ---------------------------------------------------------------------------
// clock_display_driver_if
// Bundles the strobe/level inputs and the time/display outputs of the clock
// display driver.
//   master : drives sec_tick, inc_min, inc_hour, blank; observes outputs
//   slave  : the driver itself
// Signals:
//   sec_tick, inc_min, inc_hour : one-cycle strobes
//   blank                       : level, 1 = all digits dark
//   hours_bcd/minutes_bcd/seconds_bcd : BCD {tens, ones}
//   an[3:0], seg[6:0] {g..a}, dp : display pins, polarity set by the driver
// ---------------------------------------------------------------------------
interface clock_display_driver_if;
    import seg7_pkg::*;

    logic       sec_tick;
    logic       inc_min;
    logic       inc_hour;
    logic       blank;
    bcd2_t      hours_bcd;
    bcd2_t      minutes_bcd;
    bcd2_t      seconds_bcd;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output sec_tick, inc_min, inc_hour, blank,
        input  hours_bcd, minutes_bcd, seconds_bcd, an, seg, dp
    );

    modport slave (
        input  sec_tick, inc_min, inc_hour, blank,
        output hours_bcd, minutes_bcd, seconds_bcd, an, seg, dp
    );

endinterface

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Purely combinational BCD nibble to seven-segment glyph, active-high.
//   digit_i[3:0] : BCD value; non-BCD codes (unreachable) show a dash
//   blank_i      : 1 = all segments off
//   glyph_o[6:0] : {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] glyph_o
);

    // Nibble to glyph lookup with blanking override.
    always_comb begin
        glyph_o = GLYPH_OFF;
        if (blank_i) begin
            glyph_o = GLYPH_OFF;
        end else begin
            case (digit_i)
                4'd0:    glyph_o = GLYPH_0;
                4'd1:    glyph_o = GLYPH_1;
                4'd2:    glyph_o = GLYPH_2;
                4'd3:    glyph_o = GLYPH_3;
                4'd4:    glyph_o = GLYPH_4;
                4'd5:    glyph_o = GLYPH_5;
                4'd6:    glyph_o = GLYPH_6;
                4'd7:    glyph_o = GLYPH_7;
                4'd8:    glyph_o = GLYPH_8;
                4'd9:    glyph_o = GLYPH_9;
                default: glyph_o = GLYPH_DASH;
            endcase
        end
    end

endmodule

// File: rtl/clock_display_driver.sv
// ---------------------------------------------------------------------------
// clock_display_driver
// Time-of-day keeper (BCD HH:MM:SS) advanced by a once-per-second strobe and
// settable with minute/hour increment strobes, plus a 4-digit multiplexed
// seven-segment driver showing HH.MM with the hours-ones DP as a blinking
// colon.
// Parameters:
//   SCAN_DIV       : clk cycles each digit is lit (>= 2)
//   MODE_24H       : 1 = hours 00-23, 0 = hours 01-12
//   SEG_ACTIVE_LOW : 1 = an/seg/dp active-low
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : strobes/blank in, time fields and display pins out
// ---------------------------------------------------------------------------
module clock_display_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter bit MODE_24H       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    clock_display_driver_if.slave  bus
);

    localparam int          CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam bcd2_t ZERO_BCD = bcd2_t'(8'h00);
    localparam bcd2_t MAX59    = bcd2_t'(8'h59);
    localparam bcd2_t HR_MAX   = MODE_24H ? bcd2_t'(8'h23) : bcd2_t'(8'h12);
    localparam bcd2_t HR_MIN   = MODE_24H ? bcd2_t'(8'h00) : bcd2_t'(8'h01);
    localparam bcd2_t HR_RESET = MODE_24H ? bcd2_t'(8'h00) : bcd2_t'(8'h12);

    // Inactive levels of the display pins.
    localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

    // Increment a two-digit BCD field; at max_v it wraps to min_v.
    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max_v,
                                      input bcd2_t min_v);
        bcd2_t r;
        if (v == max_v) begin
            r = min_v;
        end else if (v.ones >= 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    bcd2_t            hr_q, hr_d;
    bcd2_t            min_q, min_d;
    bcd2_t            sec_q, sec_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             scan_term_s;
    logic [3:0]       digit_nib_s;
    logic             lead_zero_s;
    logic [6:0]       glyph_s;
    logic [3:0]       an_act_s;
    logic             dp_act_s;

    // Timekeeping: set strobes take priority and discard a same-cycle tick.
    always_comb begin
        hr_d  = hr_q;
        min_d = min_q;
        sec_d = sec_q;
        if (bus.inc_min || bus.inc_hour) begin
            if (bus.inc_min) begin
                min_d = bcd_inc(min_q, MAX59, ZERO_BCD);
                sec_d = ZERO_BCD;
            end else begin
                min_d = min_q;
                sec_d = sec_q;
            end
            if (bus.inc_hour) begin
                hr_d = bcd_inc(hr_q, HR_MAX, HR_MIN);
            end else begin
                hr_d = hr_q;
            end
        end else if (bus.sec_tick) begin
            sec_d = bcd_inc(sec_q, MAX59, ZERO_BCD);
            if (sec_q == MAX59) begin
                min_d = bcd_inc(min_q, MAX59, ZERO_BCD);
                if (min_q == MAX59) begin
                    hr_d = bcd_inc(hr_q, HR_MAX, HR_MIN);
                end else begin
                    hr_d = hr_q;
                end
            end else begin
                min_d = min_q;
                hr_d  = hr_q;
            end
        end else begin
            hr_d  = hr_q;
            min_d = min_q;
            sec_d = sec_q;
        end
    end

    // Scan timing: dwell counter and digit index.
    always_comb begin
        scan_term_s = (scan_cnt_q == CNT_LAST);
        if (scan_term_s) begin
            scan_cnt_d = CNT_ZERO;
            dig_d      = dig_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + CNT_W'(1);
            dig_d      = dig_q;
        end
    end

    // Select the nibble shown at the current digit position.
    always_comb begin
        digit_nib_s = 4'd0;
        case (dig_q)
            DIG_MIN_ONES: digit_nib_s = min_q.ones;
            DIG_MIN_TENS: digit_nib_s = min_q.tens;
            DIG_HR_ONES:  digit_nib_s = hr_q.ones;
            DIG_HR_TENS:  digit_nib_s = hr_q.tens;
            default:      digit_nib_s = 4'd0;
        endcase
    end

    // In 12h mode a zero hours-tens digit is dark, but its anode still scans.
    assign lead_zero_s = (MODE_24H == 1'b0) && (dig_q == DIG_HR_TENS) &&
                         (hr_q.tens == 4'd0);

    seg7_decoder u_dec (
        .digit_i (digit_nib_s),
        .blank_i (lead_zero_s || bus.blank),
        .glyph_o (glyph_s)
    );

    // Active-high pin values before polarity; colon lit on even seconds.
    always_comb begin
        an_act_s = 4'b0000;
        dp_act_s = 1'b0;
        if (bus.blank) begin
            an_act_s = 4'b0000;
            dp_act_s = 1'b0;
        end else begin
            an_act_s = 4'b0001 << dig_q;
            dp_act_s = (dig_q == DIG_HR_ONES) && (sec_q.ones[0] == 1'b0);
        end
        an_d  = SEG_ACTIVE_LOW ? ~an_act_s : an_act_s;
        seg_d = SEG_ACTIVE_LOW ? ~glyph_s  : glyph_s;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_act_s : dp_act_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q       <= HR_RESET;
            min_q      <= ZERO_BCD;
            sec_q      <= ZERO_BCD;
            scan_cnt_q <= CNT_ZERO;
            dig_q      <= 2'd0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
        end else begin
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.hours_bcd   = hr_q;
    assign bus.minutes_bcd = min_q;
    assign bus.seconds_bcd = sec_q;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// ---------------------------------------------------------------------------
// tb_clock_display_driver
// Directed bench for clock_display_driver: one 24h and one 12h instance,
// both with a 4-cycle digit dwell and active-low display pins.
// ---------------------------------------------------------------------------
module tb_clock_display_driver;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    clock_display_driver_if bus_a ();
    clock_display_driver_if bus_b ();

    clock_display_driver #(.SCAN_DIV(4), .MODE_24H(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    clock_display_driver #(.SCAN_DIV(4), .MODE_24H(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply n consecutive cycles of the given strobes to one instance.
    task automatic pulse(input bit sel, input logic s, input logic m, input logic h, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                bus_b.sec_tick = s; bus_b.inc_min = m; bus_b.inc_hour = h;
            end else begin
                bus_a.sec_tick = s; bus_a.inc_min = m; bus_a.inc_hour = h;
            end
            @(posedge clk); #1;
        end
        bus_a.sec_tick = 1'b0; bus_a.inc_min = 1'b0; bus_a.inc_hour = 1'b0;
        bus_b.sec_tick = 1'b0; bus_b.inc_min = 1'b0; bus_b.inc_hour = 1'b0;
    endtask

    function automatic logic [3:0] an_of(input bit sel);
        return sel ? bus_b.an : bus_a.an;
    endfunction

    // Wait (bounded) for the first cycle of the 1110 slot.
    task automatic sync_scan(input bit sel);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = an_of(sel);
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (an_of(sel) === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            else prev = an_of(sel);
        end
        check("scan_sync", {31'd0, found}, 32'd1);
    endtask

    // Check 16 cycles: 4 slots x 4 cycles, expected seg per slot, dp in slot 2.
    task automatic scan_check(input bit sel, input string tag,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp2);
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
        seg_exp[0] = s0; seg_exp[1] = s1; seg_exp[2] = s2; seg_exp[3] = s3;
        sync_scan(sel);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_an"},  sel ? bus_b.an  : bus_a.an,  an_exp[i/4]);
            check({tag, "_seg"}, sel ? bus_b.seg : bus_a.seg, seg_exp[i/4]);
            check({tag, "_dp"},  sel ? bus_b.dp  : bus_a.dp,  (i/4 == 2) ? dp2 : 1'b1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus_a.sec_tick = 1'b0; bus_a.inc_min = 1'b0; bus_a.inc_hour = 1'b0; bus_a.blank = 1'b0;
        bus_b.sec_tick = 1'b0; bus_b.inc_min = 1'b0; bus_b.inc_hour = 1'b0; bus_b.blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_a_hr",  bus_a.hours_bcd,   8'h00);
        check("rst_a_min", bus_a.minutes_bcd, 8'h00);
        check("rst_a_sec", bus_a.seconds_bcd, 8'h00);
        check("rst_a_an",  bus_a.an,  4'hF);
        check("rst_a_seg", bus_a.seg, 7'h7F);
        check("rst_a_dp",  bus_a.dp,  1'b1);
        check("rst_b_hr",  bus_b.hours_bcd,   8'h12);
        check("rst_b_min", bus_b.minutes_bcd, 8'h00);
        rst_n = 1'b1;

        // Set collision at 10:20:45
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 10);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 10);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 45);
        check("pre_hr",  bus_a.hours_bcd,   8'h10);
        check("pre_min", bus_a.minutes_bcd, 8'h20);
        check("pre_sec", bus_a.seconds_bcd, 8'h45);
        pulse(1'b0, 1'b1, 1'b1, 1'b1, 1);
        check("coll_hr",  bus_a.hours_bcd,   8'h11);
        check("coll_min", bus_a.minutes_bcd, 8'h21);
        check("coll_sec", bus_a.seconds_bcd, 8'h00);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 38);
        check("min59", bus_a.minutes_bcd, 8'h59);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1);
        check("minwrap_min", bus_a.minutes_bcd, 8'h00);
        check("minwrap_hr",  bus_a.hours_bcd,   8'h11);

        // 24h full roll-over from 23:59:58
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 12);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 59);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 58);
        check("r58_hr",  bus_a.hours_bcd,   8'h23);
        check("r58_min", bus_a.minutes_bcd, 8'h59);
        check("r58_sec", bus_a.seconds_bcd, 8'h58);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1);
        check("r59_sec", bus_a.seconds_bcd, 8'h59);
        check("r59_hr",  bus_a.hours_bcd,   8'h23);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1);
        check("r00_hr",  bus_a.hours_bcd,   8'h00);
        check("r00_min", bus_a.minutes_bcd, 8'h00);
        check("r00_sec", bus_a.seconds_bcd, 8'h00);

        // 12h roll-over 12:59:59 -> 01:00:00
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 59);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 59);
        check("b_pre_hr",  bus_b.hours_bcd,   8'h12);
        check("b_pre_sec", bus_b.seconds_bcd, 8'h59);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1);
        check("b_roll_hr",  bus_b.hours_bcd,   8'h01);
        check("b_roll_min", bus_b.minutes_bcd, 8'h00);
        check("b_roll_sec", bus_b.seconds_bcd, 8'h00);

        // Scan order at 12:34, even then odd seconds
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 12);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 22);
        check("scan_min", bus_a.minutes_bcd, 8'h34);
        check("scan_hr",  bus_a.hours_bcd,   8'h12);
        scan_check(1'b0, "scan_even", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1);
        check("scan_sec", bus_a.seconds_bcd, 8'h01);
        scan_check(1'b0, "scan_odd", 7'h19, 7'h30, 7'h24, 7'h79, 1'b1);

        // 12h leading-zero at 09:05 then blank
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 8);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 5);
        check("lz_hr",  bus_b.hours_bcd,   8'h09);
        check("lz_min", bus_b.minutes_bcd, 8'h05);
        scan_check(1'b1, "lz", 7'h12, 7'h40, 7'h10, 7'h7F, 1'b0);
        bus_b.blank = 1'b1;
        @(posedge clk); #1;
        check("blank_an_next", bus_b.an, 4'hF);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1);
        check("blank_sec", bus_b.seconds_bcd, 8'h01);
        for (int i = 0; i < 6; i++) begin
            check("blank_an", bus_b.an, 4'hF);
            check("blank_dp", bus_b.dp, 1'b1);
            @(posedge clk); #1;
        end
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1);
        check("blank_sec2", bus_b.seconds_bcd, 8'h02);
        bus_b.blank = 1'b0;

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #2;
        check("mrst_a_hr",  bus_a.hours_bcd,   8'h00);
        check("mrst_a_min", bus_a.minutes_bcd, 8'h00);
        check("mrst_a_sec", bus_a.seconds_bcd, 8'h00);
        check("mrst_a_an",  bus_a.an,  4'hF);
        check("mrst_a_seg", bus_a.seg, 7'h7F);
        check("mrst_a_dp",  bus_a.dp,  1'b1);
        check("mrst_b_hr",  bus_b.hours_bcd,   8'h12);
        check("mrst_b_min", bus_b.minutes_bcd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
